// File: rtl/ysyx_23060171_gpr_wb_ctrl.sv
// GPR write-back controller: round-robin EXU/LSU arbitration onto the single
// GPR write port, plus a per-register busy scoreboard for IDU hazard stalls.
module ysyx_23060171_gpr_wb_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_wen,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] issue_rs1,
    input  logic [ADDR_WIDTH-1:0] issue_rs2,
    output logic                  issue_stall,
    input  logic                  exu_valid,
    input  logic [ADDR_WIDTH-1:0] exu_waddr,
    input  logic [DATA_WIDTH-1:0] exu_wdata,
    output logic                  exu_ready,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic                  lsu_ready,
    output logic                  gpr_wen,
    output logic [ADDR_WIDTH-1:0] gpr_waddr,
    output logic [DATA_WIDTH-1:0] gpr_wdata,
    output logic                  idle
);

    localparam int NREG = 2 ** ADDR_WIDTH;

    logic [NREG-1:0]       busy_q, busy_d;
    logic [ADDR_WIDTH:0]   pend_q, pend_d;
    logic                  rr_q, rr_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  hazard, issue_fire, xfer, set_busy, clr_busy;
    logic [ADDR_WIDTH-1:0] xaddr;
    logic [DATA_WIDTH-1:0] xdata;

    // x0 is hardwired to zero, so it can never be a hazard source.
    function automatic logic busy_at(input logic [NREG-1:0] b,
                                     input logic [ADDR_WIDTH-1:0] idx);
        return (idx != '0) && b[idx];
    endfunction

    assign hazard      = busy_at(busy_q, issue_rs1) | busy_at(busy_q, issue_rs2) |
                         (issue_wen & busy_at(busy_q, issue_rd));
    assign issue_stall = issue_valid & hazard;
    assign issue_fire  = issue_valid & ~hazard;

    // rr_q == 0 favours EXU when both sides request.
    assign exu_ready = exu_valid & (~lsu_valid | ~rr_q);
    assign lsu_ready = lsu_valid & (~exu_valid | rr_q);

    assign gpr_wen   = wen_q;
    assign gpr_waddr = waddr_q;
    assign gpr_wdata = wdata_q;
    assign idle      = (pend_q == '0);

    always_comb begin
        xfer     = exu_ready | lsu_ready;
        xaddr    = exu_ready ? exu_waddr : lsu_waddr;
        xdata    = exu_ready ? exu_wdata : lsu_wdata;
        wen_d    = xfer && (xaddr != '0);
        waddr_d  = xfer ? xaddr : waddr_q;
        wdata_d  = xfer ? xdata : wdata_q;
        rr_d     = (exu_valid & lsu_valid) ? ~rr_q : rr_q;

        set_busy = issue_fire & issue_wen & (issue_rd != '0);
        clr_busy = wen_q;

        // Clear applied before set so a same-index set wins.
        busy_d = busy_q;
        if (clr_busy) busy_d[waddr_q] = 1'b0;
        if (set_busy) busy_d[issue_rd] = 1'b1;

        pend_d = pend_q;
        case ({set_busy, clr_busy && (pend_q != '0)})
            2'b10:   pend_d = pend_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            2'b01:   pend_d = pend_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            pend_q  <= '0;
            rr_q    <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

`ifndef SYNTHESIS
    // A commit with nothing outstanding means a requester wrote an unissued rd.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        wen_q |-> (pend_q != '0));
`endif

endmodule
